// File: rtl/starfield_pkg.sv
// Shared types and the LFSR tap table for the layered starfield generator.
package starfield_pkg;

  localparam int MAX_LAYERS = 8;

  typedef logic [7:0] star_t;

  // Maximal-length Fibonacci taps; bit n-1 set for tap n. Zero means unsupported length.
  function automatic logic [23:0] lfsr_taps(input int len);
    case (len)
      17:      lfsr_taps = 24'h012000;
      18:      lfsr_taps = 24'h020400;
      19:      lfsr_taps = 24'h040023;
      20:      lfsr_taps = 24'h090000;
      21:      lfsr_taps = 24'h140000;
      22:      lfsr_taps = 24'h300000;
      23:      lfsr_taps = 24'h420000;
      24:      lfsr_taps = 24'hE10000;
      default: lfsr_taps = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/sf_layer_gen.sv
// One star layer: position counter, LFSR reseeded at count 0, density detect and dimmed brightness.
// Combinational outputs from registered state; advances only on i_en. STARFIELD_TWINKLE_EN adds o_tw.
module sf_layer_gen
  import starfield_pkg::*;
#(
  parameter int             H         = 800,
  parameter int             V         = 525,
  parameter int             LEN       = 21,
  parameter int             CW        = 19,
  parameter int             IDX       = 0,
  parameter int             DIM_SHIFT = 1,
  parameter int             INC       = -1,
  parameter logic [LEN-1:0] SEED      = '1,
  parameter logic [LEN-1:0] MASK      = '0
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_en,
  output logic  o_on,
  output star_t o_star,
`ifdef STARFIELD_TWINKLE_EN
  output logic [1:0] o_tw,
`endif
  output logic  o_wrap
);

  localparam int             T_INT     = H * V + INC - 1;
  localparam logic [CW-1:0]  T         = CW'(T_INT);
  localparam logic [23:0]    TAPS_FULL = lfsr_taps(LEN);
  localparam logic [LEN-1:0] TAPS      = TAPS_FULL[LEN-1:0];
  localparam int             SH        = IDX * DIM_SHIFT;

  if (T_INT < 1) begin : g_bad_term
    $error("sf_layer_gen: terminal count below 1");
  end
  if (TAPS_FULL == 24'h0) begin : g_bad_len
    $error("sf_layer_gen: LEN outside tap table");
  end

  logic [CW-1:0]  r_cnt;
  logic [LEN-1:0] r_sreg;
  logic           w_at_term;
  logic           w_fb;

  assign w_at_term = (r_cnt == T);
  assign w_fb      = ^(r_sreg & TAPS);

  // Reloading the seed at count 0 is what makes the pattern drift by INC per frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_sreg <= SEED;
    end else begin
      if (i_en) begin
        r_cnt <= w_at_term ? '0 : r_cnt + 1'b1;
      end
      if (r_cnt == '0) begin
        r_sreg <= SEED;
      end else if (i_en) begin
        r_sreg <= {r_sreg[LEN-2:0], w_fb};
      end
    end
  end

  assign o_on   = &(r_sreg | MASK);
  assign o_star = r_sreg[7:0] >> SH;
  assign o_wrap = i_en & w_at_term;
`ifdef STARFIELD_TWINKLE_EN
  assign o_tw   = r_sreg[9:8];
`endif

endmodule

// File: rtl/starfield_layers.sv
// Multi-layer LFSR starfield: nearest lit layer wins, registered one en cycle after LFSR state; holds while en low.
// Optional STARFIELD_TWINKLE_EN halves the winning star when its sreg[9:8] matches frame[3:2].
module starfield_layers
  import starfield_pkg::*;
#(
  parameter int                    H         = 800,
  parameter int                    V         = 525,
  parameter int                    LAYERS    = 3,
  parameter int                    LEN       = 21,
  parameter logic [8*LAYERS-1:0]   INCS      = {8'hFF, 8'hFE, 8'hFC},
  parameter logic [LEN*LAYERS-1:0] SEEDS     = {LAYERS{21'h1FFFFF}},
  parameter logic [LEN*LAYERS-1:0] MASKS     = {21'h7FF, 21'hFFF, 21'h1FFF},
  parameter int                    DIM_SHIFT = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  output logic                                          sf_on,
  output star_t                                         sf_star,
  output logic [((LAYERS > 1) ? $clog2(LAYERS) : 1)-1:0] sf_layer,
  output logic [15:0]                                   frame
);

  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int CW = $clog2(H * V + 128);

  if (LAYERS < 1 || LAYERS > MAX_LAYERS) begin : g_bad_layers
    $error("starfield_layers: LAYERS out of range");
  end

  logic [LAYERS-1:0] w_on_v;
  star_t             w_star_v [LAYERS];
  logic              w_wrap0;
  logic              w_on;
  star_t             w_star;
  logic [LW-1:0]     w_layer;
`ifdef STARFIELD_TWINKLE_EN
  logic [1:0]        w_tw_v [LAYERS];
  logic [1:0]        w_tw;
`endif

  logic              r_on;
  star_t             r_star;
  logic [LW-1:0]     r_layer;
  logic [15:0]       r_frame;

  for (genvar g = 0; g < LAYERS; g++) begin : g_layer
    logic w_wrap;
    sf_layer_gen #(
      .H(H), .V(V), .LEN(LEN), .CW(CW), .IDX(g), .DIM_SHIFT(DIM_SHIFT),
      .INC(int'($signed(INCS[8*g +: 8]))),
      .SEED(SEEDS[LEN*g +: LEN]),
      .MASK(MASKS[LEN*g +: LEN])
    ) u_gen (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (en),
      .o_on  (w_on_v[g]),
      .o_star(w_star_v[g]),
`ifdef STARFIELD_TWINKLE_EN
      .o_tw  (w_tw_v[g]),
`endif
      .o_wrap(w_wrap)
    );
    // Only the nearest layer's wrap defines the frame boundary.
    if (g == 0) begin : g_frame_src
      assign w_wrap0 = w_wrap;
    end else begin : g_nc
      logic w_wrap_unused;
      assign w_wrap_unused = w_wrap;
    end
  end

  always_comb begin
    w_on    = 1'b0;
    w_star  = '0;
    w_layer = '0;
`ifdef STARFIELD_TWINKLE_EN
    w_tw    = 2'b00;
`endif
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (w_on_v[i]) begin
        w_on    = 1'b1;
        w_star  = w_star_v[i];
        w_layer = LW'(i);
`ifdef STARFIELD_TWINKLE_EN
        w_tw    = w_tw_v[i];
`endif
      end
    end
`ifdef STARFIELD_TWINKLE_EN
    if (w_on && (w_tw == r_frame[3:2])) begin
      w_star = w_star >> 1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_on    <= 1'b0;
      r_star  <= '0;
      r_layer <= '0;
      r_frame <= '0;
    end else if (en) begin
      r_on    <= w_on;
      r_star  <= w_star;
      r_layer <= w_layer;
      if (w_wrap0) begin
        r_frame <= r_frame + 16'd1;
      end
    end
  end

  assign sf_on    = r_on;
  assign sf_star  = r_star;
  assign sf_layer = r_layer;
  assign frame    = r_frame;

endmodule

// File: tb/tb_starfield_layers.sv
// Short-frame bench for starfield_layers: three mask configurations against a position-based reference model.
module tb_starfield_layers;
  import starfield_pkg::*;

  localparam int H   = 8;
  localparam int V   = 4;
  localparam int NL  = 2;
  localparam int LEN = 21;
  localparam int ND  = 3;
  localparam logic [LEN-1:0] SEED = 21'h1FFFFF;
  localparam logic [LEN-1:0] ONES = 21'h1FFFFF;

  typedef struct {
    logic       on;
    logic [7:0] st;
    logic       lay;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       on_o  [ND];
  star_t      star_o[ND];
  logic [0:0] lay_o [ND];
  logic [15:0] frm_o[ND];

  // Layer 0 drifts -1 per frame, layer 1 drifts -2.
  int term [NL] = '{H*V - 1 - 1, H*V - 2 - 1};
  logic [LEN-1:0] mask [ND][NL] = '{'{21'h0, 21'h0}, '{ONES, ONES}, '{21'h0, ONES}};

  starfield_layers #(.H(H), .V(V), .LAYERS(2), .LEN(LEN), .INCS({8'hFE, 8'hFF}),
    .SEEDS({2{SEED}}), .MASKS({21'h0, 21'h0}), .DIM_SHIFT(1))
  u_sparse (.clk(clk), .rst(rst), .en(en), .sf_on(on_o[0]), .sf_star(star_o[0]),
    .sf_layer(lay_o[0]), .frame(frm_o[0]));

  starfield_layers #(.H(H), .V(V), .LAYERS(2), .LEN(LEN), .INCS({8'hFE, 8'hFF}),
    .SEEDS({2{SEED}}), .MASKS({ONES, ONES}), .DIM_SHIFT(1))
  u_dense (.clk(clk), .rst(rst), .en(en), .sf_on(on_o[1]), .sf_star(star_o[1]),
    .sf_layer(lay_o[1]), .frame(frm_o[1]));

  starfield_layers #(.H(H), .V(V), .LAYERS(2), .LEN(LEN), .INCS({8'hFE, 8'hFF}),
    .SEEDS({2{SEED}}), .MASKS({ONES, 21'h0}), .DIM_SHIFT(1))
  u_l1 (.clk(clk), .rst(rst), .en(en), .sf_on(on_o[2]), .sf_star(star_o[2]),
    .sf_layer(lay_o[2]), .frame(frm_o[2]));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: star pattern is a function of each layer's position within its own frame.
  logic [LEN-1:0] seq [0:40];
  int             pos    [NL];
  bit             seeded [NL];
  logic [15:0]    m_frame;
  exp_t           ex   [ND];
  exp_t           gold [ND][31];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LEN-1:0] sreg_of(input int i);
    if (pos[i] == 0) return seeded[i] ? seq[0] : seq[term[i]];
    return seq[pos[i] - 1];
  endfunction

  function automatic exp_t predict(input int d);
    exp_t x;
    logic [LEN-1:0] s;
    logic [1:0] tw;
    x.on = 1'b0; x.st = 8'h00; x.lay = 1'b0; tw = 2'b00;
    for (int i = 0; i < NL; i++) begin
      s = sreg_of(i);
      if (!x.on && (&(s | mask[d][i]))) begin
        x.on = 1'b1; x.st = s[7:0] >> i; x.lay = 1'(i); tw = s[9:8];
      end
    end
`ifdef STARFIELD_TWINKLE_EN
    if (x.on && tw == m_frame[3:2]) x.st = x.st >> 1;
`endif
    return x;
  endfunction

  task automatic model_edge(input logic e, input logic r);
    bit wrap;
    if (r) begin
      for (int i = 0; i < NL; i++) begin pos[i] = 0; seeded[i] = 1'b1; end
      m_frame = 16'h0;
      for (int d = 0; d < ND; d++) begin ex[d].on = 1'b0; ex[d].st = 8'h0; ex[d].lay = 1'b0; end
    end else begin
      if (e) for (int d = 0; d < ND; d++) ex[d] = predict(d);
      wrap = e && (pos[0] == term[0]);
      for (int i = 0; i < NL; i++) begin
        if (pos[i] == 0) seeded[i] = 1'b1;
        if (e) begin
          if (pos[i] == term[i]) begin pos[i] = 0; seeded[i] = 1'b0; end
          else pos[i]++;
        end
      end
      if (wrap) m_frame++;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d.on", d),    32'(on_o[d]),   32'(ex[d].on));
      check($sformatf("d%0d.star", d),  32'(star_o[d]), 32'(ex[d].st));
      check($sformatf("d%0d.layer", d), 32'(lay_o[d]),  32'(ex[d].lay));
      check($sformatf("d%0d.frame", d), 32'(frm_o[d]),  32'(m_frame));
    end
  endtask

  task automatic step(input logic e, input logic r);
    en = e; rst = r;
    @(posedge clk);
    model_edge(e, r);
    #1;
    check_all();
  endtask

  initial begin
    logic [23:0] taps_full;
    logic [LEN-1:0] taps;
    taps_full = lfsr_taps(LEN);
    taps = taps_full[LEN-1:0];
    seq[0] = SEED;
    for (int k = 1; k <= 40; k++) seq[k] = {seq[k-1][LEN-2:0], ^(seq[k-1] & taps)};

    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst.on", 32'(on_o[0]), 32'h0);
    check("rst.star", 32'(star_o[1]), 32'h0);
    check("rst.frame", 32'(frm_o[0]), 32'h0);

    // First frame: 31 en cycles, frame ticks on the last one
    for (int k = 1; k <= 31; k++) begin
      step(1'b1, 1'b0);
      for (int d = 0; d < ND; d++) gold[d][k-1] = ex[d];
      if (k == 1) begin
        check("f0.seed_on", 32'(on_o[0]), 32'h1);
        check("f0.seed_star", 32'(star_o[0]), 32'hFF);
        check("f0.dense_layer", 32'(lay_o[1]), 32'h0);
      end
      if (k == 3) begin
        check("f0.sparse_off", 32'(on_o[0]), 32'h0);
        check("f0.l1_star", 32'(star_o[2]), 32'h7F);
        check("f0.l1_layer", 32'(lay_o[2]), 32'h1);
      end
      if (k == 30) check("f0.frame_before", 32'(frm_o[0]), 32'h0);
      if (k == 31) check("f0.frame_wrap", 32'(frm_o[0]), 32'h1);
    end

    // en pulses separated by idle cycles
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Mid-frame reset at cnt_0 = 13, then replay of the first frame
    step(1'b0, 1'b1);
    for (int k = 0; k < 13; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("mid.on", 32'(on_o[1]), 32'h0);
    check("mid.frame", 32'(frm_o[1]), 32'h0);
    for (int k = 0; k < 31; k++) begin
      step(1'b1, 1'b0);
      for (int d = 0; d < ND; d++) begin
        check($sformatf("replay.d%0d.on", d), 32'(on_o[d]), 32'(gold[d][k].on));
        check($sformatf("replay.d%0d.star", d), 32'(star_o[d]), 32'(gold[d][k].st));
      end
    end

    // Reset coinciding with the layer-0 wrap: frame must not tick
    step(1'b0, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("rstwrap.frame", 32'(frm_o[0]), 32'h0);

    // Random en/rst traffic over many frames
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
